// File: rtl/g15_pkg.sv
// Shared word-format constants for the G-15 serial arithmetic slice.
package g15_pkg;

    localparam int WORD_BITS = 29;
    localparam int BIT_CNT_W = 5;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_BITS - 1);

endpackage

// File: rtl/serial_add_bit.sv
// One-bit full-adder cell shared by the AR and PN serial adders.
module serial_add_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/sr_ff.sv
// Set/reset flip-flop with synchronous reset; clear has priority over set.
module sr_ff (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_set,
    input  logic i_clr,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)      r_q <= 1'b0;
        else if (i_clr) r_q <= 1'b0;
        else if (i_set) r_q <= 1'b1;
    end

    assign o_q = r_q;

endmodule

// File: rtl/ar_pn_adder.sv
// Serial AR / PN adder with bit-timing check.
// Macro G15_PN_ADDER_EN enables the double-word PN path.
module ar_pn_adder
    import g15_pkg::*;
(
    input  logic CLOCK,
    input  logic rst,
    input  logic IB,
    input  logic LINE_AR,
    input  logic LINE_PN,
    input  logic AA,
    input  logic PA,
    input  logic TS,
    input  logic ODD_WORD,
    input  logic PG_CLEAR,
    output logic AR_W,
    output logic PN_W,
    output logic AC,
    output logic PC,
    output logic AR,
    output logic PP,
    output logic DA_OVFLW,
    output logic SYNC_ERR
);

    logic                 r_ac;
    logic [BIT_CNT_W-1:0] r_cnt;
    logic                 w_ar_sum;
    logic                 w_ar_cy;
    logic                 w_armed;
    logic                 w_sync_err;

    serial_add_bit u_ar_add (
        .i_a     (LINE_AR),
        .i_b     (IB),
        .i_c     (r_ac),
        .o_sum   (w_ar_sum),
        .o_carry (w_ar_cy)
    );

    assign AR_W = PG_CLEAR ? 1'b0 : (AA ? w_ar_sum : LINE_AR);

    always_ff @(posedge CLOCK) begin
        if (rst)                     r_ac <= 1'b0;
        else if (TS | PG_CLEAR | ~AA) r_ac <= 1'b0;
        else                         r_ac <= w_ar_cy;
    end

    sr_ff u_ar_sign (
        .i_clk (CLOCK),
        .i_rst (rst),
        .i_set (TS & AA & LINE_AR),
        .i_clr (PG_CLEAR | (TS & AA & ~LINE_AR)),
        .o_q   (AR)
    );

    assign AC = r_ac;

`ifdef G15_PN_ADDER_EN
    logic r_pc;
    logic r_da;
    logic w_pn_sum;
    logic w_pn_cy;
    logic w_pn_top;

    serial_add_bit u_pn_add (
        .i_a     (LINE_PN),
        .i_b     (IB),
        .i_c     (r_pc),
        .o_sum   (w_pn_sum),
        .o_carry (w_pn_cy)
    );

    // Only the odd word's sign slot ends the 58-bit carry chain.
    assign w_pn_top = TS & ODD_WORD;
    assign PN_W     = PG_CLEAR ? 1'b0 : (PA ? w_pn_sum : LINE_PN);

    always_ff @(posedge CLOCK) begin
        if (rst)                           r_pc <= 1'b0;
        else if (w_pn_top | PG_CLEAR | ~PA) r_pc <= 1'b0;
        else                               r_pc <= w_pn_cy;
    end

    // LINE_PN is the value PP takes at this edge: the augend sign.
    always_ff @(posedge CLOCK) begin
        if (rst) r_da <= 1'b0;
        else     r_da <= w_pn_top & PA & ~PG_CLEAR
                         & (LINE_PN == IB) & (PN_W != LINE_PN);
    end

    sr_ff u_pn_sign (
        .i_clk (CLOCK),
        .i_rst (rst),
        .i_set (w_pn_top & PA & LINE_PN),
        .i_clr (PG_CLEAR | (w_pn_top & PA & ~LINE_PN)),
        .o_q   (PP)
    );

    assign PC       = r_pc;
    assign DA_OVFLW = r_da;
`else
    logic w_unused;

    assign w_unused = ^{PA, ODD_WORD};
    assign PN_W     = LINE_PN;
    assign PC       = 1'b0;
    assign PP       = 1'b0;
    assign DA_OVFLW = 1'b0;
`endif

    always_ff @(posedge CLOCK) begin
        if (rst)                  r_cnt <= '0;
        else if (TS)              r_cnt <= BIT_CNT_W'(1);
        else if (r_cnt == LAST_BIT) r_cnt <= '0;
        else                      r_cnt <= r_cnt + BIT_CNT_W'(1);
    end

    // Word framing is only checked once a first TS has been seen.
    sr_ff u_armed (
        .i_clk (CLOCK),
        .i_rst (rst),
        .i_set (TS),
        .i_clr (1'b0),
        .o_q   (w_armed)
    );

    assign w_sync_err = w_armed & (TS ? (r_cnt != '0) : (r_cnt == '0));

    sr_ff u_sync (
        .i_clk (CLOCK),
        .i_rst (rst),
        .i_set (w_sync_err),
        .i_clr (1'b0),
        .o_q   (SYNC_ERR)
    );

endmodule
